// File: rtl/isa_camac_bus_bridge.sv
// Bridges byte-wide ISA I/O accesses in a fixed address window onto CB_DATA_WIDTH-bit CAMAC registers.
// CHRDY stays low through the CAMAC handshake (bounded by TIMEOUT) plus WAIT_STATES cycles.
module isa_camac_bus_bridge #(
    parameter logic [9:0] BASE_ADDR     = 10'h100,
    parameter int         NUM_REGS      = 8,
    parameter int         CB_DATA_WIDTH = 16,
    parameter int         WAIT_STATES   = 4,
    parameter int         TIMEOUT       = 64,
    localparam int        RAW           = $clog2(NUM_REGS)
) (
    input  logic                     isa_clk,
    input  logic                     isa_reset,
    input  logic [9:0]               isa_addr,
    input  logic                     isa_ale,
    input  logic                     isa_aen,
    input  logic                     isa_ior,
    input  logic                     isa_iow,
    input  logic [7:0]               isa_data_in,
    output logic [7:0]               isa_data_out,
    output logic                     isa_data_oe,
    output logic                     isa_chrdy,
    output logic [RAW-1:0]           cb_addr,
    output logic [CB_DATA_WIDTH-1:0] cb_wdata,
    output logic                     cb_wr,
    output logic                     cb_rd,
    input  logic [CB_DATA_WIDTH-1:0] cb_rdata,
    input  logic                     cb_ack,
    input  logic                     err_clr,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_CAMAC, ST_WAIT, ST_HOLD} state_t;

    localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(WAIT_STATES - 1);
    localparam logic [10:0] WIN_END   = 11'(BASE_ADDR) + 11'(2 * NUM_REGS);

    logic [9:0]               r_addr;
    logic                     r_aen;
    logic                     r_ior_s1, r_ior_s2, r_ior_s3;
    logic                     r_iow_s1, r_iow_s2, r_iow_s3;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [7:0]               r_cnt;
    logic                     r_is_read;
    logic                     r_hi;
    logic [7:0]               r_lo;
    logic [CB_DATA_WIDTH-1:0] r_snap;

    logic [9:0]     w_offset;
    logic [RAW-1:0] w_idx;
    logic           w_bsel;
    logic           w_hit;
    logic           w_ior_fall, w_iow_fall;
    logic           w_rd_start, w_wr_start;
    logic           w_ack, w_tmo;
    logic           w_strobe_hi;
    logic [7:0]     w_hi_byte;

    assign w_offset    = r_addr - BASE_ADDR;
    assign w_idx       = RAW'(w_offset >> 1);
    assign w_bsel      = w_offset[0];
    assign w_hit       = !r_aen && ({1'b0, r_addr} >= 11'(BASE_ADDR)) && ({1'b0, r_addr} < WIN_END);
    assign w_ior_fall  = r_ior_s3 && !r_ior_s2;
    assign w_iow_fall  = r_iow_s3 && !r_iow_s2;
    // A falling strobe only counts while the other strobe is high; both low together is ignored.
    assign w_rd_start  = w_ior_fall && r_iow_s2 && w_hit;
    assign w_wr_start  = w_iow_fall && r_ior_s2 && w_hit;
    assign w_ack       = (r_state == ST_CAMAC) && cb_ack;
    assign w_tmo       = (r_state == ST_CAMAC) && !cb_ack && (r_cnt == TMO_LAST);
    // Level rather than edge, so a strobe released early during CAMAC/WAIT cannot strand HOLD.
    assign w_strobe_hi = r_is_read ? r_ior_s2 : r_iow_s2;
    assign w_hi_byte   = 8'(r_snap[CB_DATA_WIDTH-1:8]);

    always_ff @(posedge isa_clk) begin
        if (!isa_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_start) begin
                    w_state_nxt = w_bsel ? ST_HOLD : ST_CAMAC;
                end else if (w_wr_start) begin
                    w_state_nxt = w_bsel ? ST_CAMAC : ST_HOLD;
                end
            end
            ST_CAMAC: begin
                if (w_ack || w_tmo) begin
                    w_state_nxt = (WAIT_STATES == 0) ? ST_HOLD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_strobe_hi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        isa_chrdy    = 1'b1;
        isa_data_oe  = 1'b0;
        isa_data_out = 8'h00;
        if (r_state == ST_CAMAC || r_state == ST_WAIT) begin
            isa_chrdy = 1'b0;
        end
        if (r_is_read && r_state != ST_IDLE) begin
            isa_data_oe  = 1'b1;
            isa_data_out = r_hi ? w_hi_byte : r_snap[7:0];
        end
    end

    always_ff @(posedge isa_clk) begin
        if (!isa_reset) begin
            r_addr      <= '0;
            r_aen       <= 1'b0;
            r_ior_s1    <= 1'b0;
            r_ior_s2    <= 1'b0;
            r_ior_s3    <= 1'b0;
            r_iow_s1    <= 1'b0;
            r_iow_s2    <= 1'b0;
            r_iow_s3    <= 1'b0;
            r_cnt       <= '0;
            r_is_read   <= 1'b0;
            r_hi        <= 1'b0;
            r_lo        <= '0;
            r_snap      <= '0;
            cb_addr     <= '0;
            cb_wdata    <= '0;
            cb_wr       <= 1'b0;
            cb_rd       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (isa_ale) begin
                r_addr <= isa_addr;
                r_aen  <= isa_aen;
            end
            r_ior_s1 <= isa_ior;
            r_ior_s2 <= r_ior_s1;
            r_ior_s3 <= r_ior_s2;
            r_iow_s1 <= isa_iow;
            r_iow_s2 <= r_iow_s1;
            r_iow_s3 <= r_iow_s2;
            r_cnt    <= (w_state_nxt != r_state) ? 8'd0 : 8'(r_cnt + 8'd1);
            cb_wr    <= 1'b0;
            cb_rd    <= 1'b0;

            if (r_state == ST_IDLE) begin
                if (w_rd_start) begin
                    r_is_read <= 1'b1;
                    r_hi      <= w_bsel;
                    if (!w_bsel) begin
                        cb_addr <= w_idx;
                        cb_rd   <= 1'b1;
                    end
                end else if (w_wr_start) begin
                    r_is_read <= 1'b0;
                    r_hi      <= w_bsel;
                    if (w_bsel) begin
                        cb_addr  <= w_idx;
                        cb_wdata <= {isa_data_in[CB_DATA_WIDTH-9:0], r_lo};
                        cb_wr    <= 1'b1;
                    end else begin
                        r_lo <= isa_data_in;
                    end
                end
            end

            if (w_ack && r_is_read) begin
                r_snap <= cb_rdata;
            end else if (w_tmo) begin
                r_snap <= '1;
            end

            if (w_tmo) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
